// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, ALU operations and stage-register bundles
// shared by the EX/MEM/WB back end and its ALU.
package riscv_pkg;

    localparam int PKG_XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } aluop_e;

    typedef struct packed {
        logic                regwrite;
        logic                memread;
        logic                memwrite;
        logic                branch;
        logic                alusrc;
        aluop_e              aluop;
        logic [2:0]          funct3;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] imm;
        logic [PKG_XLEN-1:0] rs1_val;
        logic [PKG_XLEN-1:0] rs2_val;
    } idex_t;

    typedef struct packed {
        logic                regwrite;
        logic                memread;
        logic                memwrite;
        logic [4:0]          rd;
        logic [PKG_XLEN-1:0] alu;
        logic [PKG_XLEN-1:0] rs2_val;
    } exmem_t;

    typedef struct packed {
        logic                regwrite;
        logic                memread;
        logic [4:0]          rd;
        logic [PKG_XLEN-1:0] alu;
        logic [PKG_XLEN-1:0] load;
    } memwb_t;

    // sub only exists for R-type; bit 30 picks sra for both.
    function automatic aluop_e alu_decode(
        input logic [2:0] f3,
        input logic       f7b5,
        input logic       is_r
    );
        aluop_e op;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational integer ALU plus branch compare flags.
// Ports: a_i/b_i operands, aluop_i; result_o, eq_o, lt_o, ltu_o.
module riscv_alu
    import riscv_pkg::*;
#(
    parameter int XLEN = PKG_XLEN
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  aluop_e          aluop_i,
    output logic [XLEN-1:0] result_o,
    output logic            eq_o,
    output logic            lt_o,
    output logic            ltu_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];
    assign eq_o  = (a_i == b_i);
    assign lt_o  = ($signed(a_i) < $signed(b_i));
    assign ltu_o = (a_i < b_i);

    always_comb begin
        result_o = '0;
        unique case (aluop_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_o};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, ltu_o};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $signed(a_i) >>> shamt;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/riscv_ex_mem_wb.sv
// riscv_ex_mem_wb: ID/EX, EX/MEM, MEM/WB registers, forwarding, hazards.
// In: decode fields, dmem_rdata. Out: dmem port, redirect, stall, WB.
module riscv_ex_mem_wb
    import riscv_pkg::*;
#(
    parameter int XLEN = PKG_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_ID,
    input  logic [XLEN-1:0] IMM_ID,
    input  logic [XLEN-1:0] REG_DATA1_ID,
    input  logic [XLEN-1:0] REG_DATA2_ID,
    input  logic [2:0]      FUNCT3_ID,
    input  logic [6:0]      FUNCT7_ID,
    input  logic [6:0]      OPCODE_ID,
    input  logic [4:0]      RD_ID,
    input  logic [4:0]      RS1_ID,
    input  logic [4:0]      RS2_ID,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            dmem_we,
    output logic            PCSrc,
    output logic [XLEN-1:0] PC_Branch,
    output logic            IF_ID_write,
    output logic            PC_write,
    output logic            IF_ID_flush,
    output logic            RegWrite_WB,
    output logic [4:0]      RD_WB,
    output logic [XLEN-1:0] ALU_DATA_WB
);

    idex_t  idex_q, idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic            id_regwrite;
    logic            id_memread;
    logic            id_memwrite;
    logic            id_branch;
    logic            id_alusrc;
    logic            id_reads_rs2;
    aluop_e          id_aluop;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;

    logic            fwd_ex1, fwd_ex2;
    logic            fwd_wb1, fwd_wb2;
    logic [XLEN-1:0] ex_rs1, ex_rs2;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    logic            cmp_eq, cmp_lt, cmp_ltu;
    logic            br_cond;
    logic            stall;
    logic            hold;
    logic [XLEN-1:0] wb_data;
    logic            unused_ok;

    assign unused_ok = ^{FUNCT7_ID[6], FUNCT7_ID[4:0]};

    always_comb begin
        id_regwrite  = 1'b0;
        id_memread   = 1'b0;
        id_memwrite  = 1'b0;
        id_branch    = 1'b0;
        id_alusrc    = 1'b0;
        id_reads_rs2 = 1'b0;
        id_aluop     = ALU_ADD;
        unique case (1'b1)
            OPCODE_ID == OP_R: begin
                id_regwrite  = 1'b1;
                id_reads_rs2 = 1'b1;
                id_aluop     = alu_decode(FUNCT3_ID,
                                          FUNCT7_ID[5], 1'b1);
            end
            OPCODE_ID == OP_I: begin
                id_regwrite = 1'b1;
                id_alusrc   = 1'b1;
                id_aluop    = alu_decode(FUNCT3_ID,
                                         FUNCT7_ID[5], 1'b0);
            end
            OPCODE_ID == OP_LOAD: begin
                id_regwrite = 1'b1;
                id_memread  = 1'b1;
                id_alusrc   = 1'b1;
            end
            OPCODE_ID == OP_STORE: begin
                id_memwrite  = 1'b1;
                id_alusrc    = 1'b1;
                id_reads_rs2 = 1'b1;
            end
            OPCODE_ID == OP_BRANCH: begin
                id_branch    = 1'b1;
                id_reads_rs2 = 1'b1;
                id_aluop     = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign wb_data     = memwb_q.memread ? memwb_q.load : memwb_q.alu;
    assign RegWrite_WB = memwb_q.regwrite && (memwb_q.rd != 5'd0);
    assign RD_WB       = memwb_q.rd;
    assign ALU_DATA_WB = wb_data;

    // Register file is written on the same edge ID/EX captures.
    assign id_rs1_val = (RegWrite_WB && RD_WB == RS1_ID)
                      ? wb_data : REG_DATA1_ID;
    assign id_rs2_val = (RegWrite_WB && RD_WB == RS2_ID)
                      ? wb_data : REG_DATA2_ID;

    // A load in EX/MEM has no data yet; load-use stall covers it.
    assign fwd_ex1 = exmem_q.regwrite && !exmem_q.memread
                  && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1;
    assign fwd_ex2 = exmem_q.regwrite && !exmem_q.memread
                  && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2;
    assign fwd_wb1 = RegWrite_WB && RD_WB == idex_q.rs1;
    assign fwd_wb2 = RegWrite_WB && RD_WB == idex_q.rs2;

    assign ex_rs1 = fwd_ex1 ? exmem_q.alu
                  : fwd_wb1 ? wb_data : idex_q.rs1_val;
    assign ex_rs2 = fwd_ex2 ? exmem_q.alu
                  : fwd_wb2 ? wb_data : idex_q.rs2_val;
    assign alu_b  = idex_q.alusrc ? idex_q.imm : ex_rs2;

    riscv_alu #(
        .XLEN     (XLEN)
    ) u_alu (
        .a_i      (ex_rs1),
        .b_i      (alu_b),
        .aluop_i  (idex_q.aluop),
        .result_o (alu_res),
        .eq_o     (cmp_eq),
        .lt_o     (cmp_lt),
        .ltu_o    (cmp_ltu)
    );

    always_comb begin
        br_cond = 1'b0;
        case (idex_q.funct3)
            3'b000:  br_cond = cmp_eq;
            3'b001:  br_cond = !cmp_eq;
            3'b100:  br_cond = cmp_lt;
            3'b101:  br_cond = !cmp_lt;
            3'b110:  br_cond = cmp_ltu;
            3'b111:  br_cond = !cmp_ltu;
            default: br_cond = 1'b0;
        endcase
    end

    assign PCSrc       = idex_q.branch && br_cond;
    assign PC_Branch   = idex_q.pc + idex_q.imm;
    assign IF_ID_flush = PCSrc;

    assign stall = idex_q.memread && idex_q.rd != 5'd0
                && (idex_q.rd == RS1_ID
                    || (id_reads_rs2 && idex_q.rd == RS2_ID));

    // A taken branch squashes the consumer, so never freeze fetch.
    assign hold        = stall && !PCSrc;
    assign PC_write    = !hold;
    assign IF_ID_write = !hold;

    always_comb begin
        idex_d = '0;
        if (!PCSrc && !stall) begin
            idex_d.regwrite = id_regwrite;
            idex_d.memread  = id_memread;
            idex_d.memwrite = id_memwrite;
            idex_d.branch   = id_branch;
            idex_d.alusrc   = id_alusrc;
            idex_d.aluop    = id_aluop;
            idex_d.funct3   = FUNCT3_ID;
            idex_d.rd       = RD_ID;
            idex_d.rs1      = RS1_ID;
            idex_d.rs2      = RS2_ID;
            idex_d.pc       = PC_ID;
            idex_d.imm      = IMM_ID;
            idex_d.rs1_val  = id_rs1_val;
            idex_d.rs2_val  = id_rs2_val;
        end
    end

    always_comb begin
        exmem_d          = '0;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memread  = idex_q.memread;
        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.rd       = idex_q.rd;
        exmem_d.alu      = alu_res;
        exmem_d.rs2_val  = ex_rs2;
    end

    always_comb begin
        memwb_d          = '0;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.memread  = exmem_q.memread;
        memwb_d.rd       = exmem_q.rd;
        memwb_d.alu      = exmem_q.alu;
        memwb_d.load     = dmem_rdata;
    end

    assign dmem_addr  = exmem_q.alu;
    assign dmem_wdata = exmem_q.rs2_val;
    assign dmem_we    = exmem_q.memwrite;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

endmodule

// File: tb/tb_riscv_ex_mem_wb.sv
// tb_riscv_ex_mem_wb: directed vectors with a write-back scoreboard.
// Stimulus pushes expected writes; a forked monitor pops and compares.
module tb_riscv_ex_mem_wb;

    localparam logic [6:0] T_R  = 7'b0110011;
    localparam logic [6:0] T_I  = 7'b0010011;
    localparam logic [6:0] T_LD = 7'b0000011;
    localparam logic [6:0] T_ST = 7'b0100011;
    localparam logic [6:0] T_BR = 7'b1100011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID;
    logic [2:0]  FUNCT3_ID;
    logic [6:0]  FUNCT7_ID, OPCODE_ID;
    logic [4:0]  RD_ID, RS1_ID, RS2_ID;
    logic [31:0] dmem_rdata, dmem_addr, dmem_wdata;
    logic        dmem_we, PCSrc, IF_ID_write, PC_write, IF_ID_flush;
    logic [31:0] PC_Branch, ALU_DATA_WB;
    logic        RegWrite_WB;
    logic [4:0]  RD_WB;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          gap;
    } exp_t;

    exp_t        q[$];
    logic [31:0] rf [0:31];
    logic [31:0] mem [0:15];
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_wb = 0;

    always #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr[5:2]];

    riscv_ex_mem_wb #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .PC_ID        (PC_ID),
        .IMM_ID       (IMM_ID),
        .REG_DATA1_ID (REG_DATA1_ID),
        .REG_DATA2_ID (REG_DATA2_ID),
        .FUNCT3_ID    (FUNCT3_ID),
        .FUNCT7_ID    (FUNCT7_ID),
        .OPCODE_ID    (OPCODE_ID),
        .RD_ID        (RD_ID),
        .RS1_ID       (RS1_ID),
        .RS2_ID       (RS2_ID),
        .dmem_rdata   (dmem_rdata),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_we      (dmem_we),
        .PCSrc        (PCSrc),
        .PC_Branch    (PC_Branch),
        .IF_ID_write  (IF_ID_write),
        .PC_write     (PC_write),
        .IF_ID_flush  (IF_ID_flush),
        .RegWrite_WB  (RegWrite_WB),
        .RD_WB        (RD_WB),
        .ALU_DATA_WB  (ALU_DATA_WB)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd,
                        input logic [31:0] data,
                        input int gap);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        e.gap  = gap;
        q.push_back(e);
    endtask

    task automatic drive(input logic [6:0] op,
                         input logic [2:0] f3,
                         input logic [6:0] f7,
                         input logic [4:0] rd,
                         input logic [4:0] rs1,
                         input logic [4:0] rs2,
                         input logic [31:0] imm,
                         input logic [31:0] pc);
        OPCODE_ID    = op;
        FUNCT3_ID    = f3;
        FUNCT7_ID    = f7;
        RD_ID        = rd;
        RS1_ID       = rs1;
        RS2_ID       = rs2;
        IMM_ID       = imm;
        PC_ID        = pc;
        REG_DATA1_ID = rf[rs1];
        REG_DATA2_ID = rf[rs2];
    endtask

    task automatic nop();
        drive(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic r_type(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2);
        drive(T_R, f3, f7, rd, rs1, rs2, 32'd0, 32'd0);
    endtask

    task automatic i_type(input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [11:0] imm, input logic [31:0] pc);
        drive(op, f3, imm[11:5], rd, rs1, imm[4:0],
              {{20{imm[11]}}, imm}, pc);
    endtask

    task automatic s_type(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [11:0] imm);
        drive(T_ST, 3'b010, imm[11:5], imm[4:0], rs1, rs2,
              {{20{imm[11]}}, imm}, 32'd0);
    endtask

    task automatic b_type(input logic [2:0] f3, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] pc);
        drive(T_BR, f3, 7'h00, 5'd0, rs1, rs2, imm, pc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            nop();
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (dmem_we) mem[dmem_addr[5:2]] = dmem_wdata;
            if (RegWrite_WB) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL wb_unexpected: got x%0d=%h want none",
                             RD_WB, ALU_DATA_WB);
                end else begin
                    e = q.pop_front();
                    chk("wb_rd", 32'(RD_WB), 32'(e.rd));
                    chk("wb_data", ALU_DATA_WB, e.data);
                    if (e.gap != 0)
                        chk("wb_gap", 32'(cyc - last_wb), 32'(e.gap));
                end
                last_wb = cyc;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        rf[2]  = 32'hDEADBEEF;
        rf[11] = 32'hFFFFFFFF;
        rf[12] = 32'h00000001;
        rf[23] = 32'h80000000;
        mem[4] = 32'd7;
        nop();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_pcsrc", 32'(PCSrc), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_regwrite", 32'(RegWrite_WB), 32'd0);
        chk("rst_rd", 32'(RD_WB), 32'd0);
        chk("rst_wbdata", ALU_DATA_WB, 32'd0);
        chk("rst_target", PC_Branch, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_ifid_w", 32'(IF_ID_write), 32'd1);
        chk("rst_pc_w", 32'(PC_write), 32'd1);
        chk("rst_flush", 32'(IF_ID_flush), 32'd0);
        fork
            monitor();
        join_none
        step();
        step();
        reset = 1'b1;

        // Dependent chain through EX/MEM and MEM/WB forwarding.
        step(); i_type(T_I, 3'b000, 5'd1, 5'd0, 12'd5, 32'd0);
        push(5'd1, 32'd5, 0);
        step(); r_type(7'h00, 3'b000, 5'd2, 5'd1, 5'd1);
        push(5'd2, 32'd10, 1);
        @(negedge clk);
        chk("chain_pcw1", 32'(PC_write), 32'd1);
        step(); r_type(7'h00, 3'b000, 5'd3, 5'd2, 5'd1);
        push(5'd3, 32'd15, 1);
        @(negedge clk);
        chk("chain_pcw2", 32'(PC_write), 32'd1);
        idle(4);

        // Load-use: one stall cycle, consumer held in ID.
        step(); i_type(T_LD, 3'b010, 5'd4, 5'd0, 12'd16, 32'd0);
        push(5'd4, 32'd7, 0);
        step(); r_type(7'h00, 3'b000, 5'd5, 5'd4, 5'd4);
        push(5'd5, 32'd14, 2);
        @(negedge clk);
        chk("lu_pcw", 32'(PC_write), 32'd0);
        chk("lu_ifidw", 32'(IF_ID_write), 32'd0);
        step();
        @(negedge clk);
        chk("lu_pcw_rel", 32'(PC_write), 32'd1);
        chk("lu_ifidw_rel", 32'(IF_ID_write), 32'd1);
        idle(4);

        // Taken beq at 0x20; the younger addi x7 must be squashed.
        step(); b_type(3'b000, 5'd0, 5'd0, 32'd8, 32'h20);
        step(); i_type(T_I, 3'b000, 5'd7, 5'd0, 12'd1, 32'h24);
        @(negedge clk);
        chk("br_pcsrc", 32'(PCSrc), 32'd1);
        chk("br_target", PC_Branch, 32'h28);
        chk("br_flush", 32'(IF_ID_flush), 32'd1);
        chk("br_pcw", 32'(PC_write), 32'd1);
        step(); nop();
        @(negedge clk);
        chk("br_pcsrc_drop", 32'(PCSrc), 32'd0);
        chk("br_flush_drop", 32'(IF_ID_flush), 32'd0);
        idle(4);

        // Branch in EX with a load consumer behind it in ID.
        step(); i_type(T_LD, 3'b010, 5'd8, 5'd0, 12'd16, 32'h38);
        push(5'd8, 32'd7, 0);
        step(); b_type(3'b000, 5'd0, 5'd0, 32'd12, 32'h40);
        step(); r_type(7'h00, 3'b000, 5'd9, 5'd8, 5'd8);
        @(negedge clk);
        chk("bs_pcsrc", 32'(PCSrc), 32'd1);
        chk("bs_target", PC_Branch, 32'h4C);
        chk("bs_pcw", 32'(PC_write), 32'd1);
        chk("bs_ifidw", 32'(IF_ID_write), 32'd1);
        chk("bs_flush", 32'(IF_ID_flush), 32'd1);
        idle(4);

        // ALU operations on register-file operands.
        step(); r_type(7'h20, 3'b000, 5'd13, 5'd11, 5'd12);
        push(5'd13, 32'hFFFFFFFE, 0);
        step(); r_type(7'h20, 3'b101, 5'd14, 5'd11, 5'd12);
        push(5'd14, 32'hFFFFFFFF, 1);
        step(); r_type(7'h00, 3'b101, 5'd21, 5'd11, 5'd12);
        push(5'd21, 32'h7FFFFFFF, 1);
        step(); r_type(7'h00, 3'b010, 5'd15, 5'd11, 5'd12);
        push(5'd15, 32'd1, 1);
        step(); r_type(7'h00, 3'b011, 5'd16, 5'd11, 5'd12);
        push(5'd16, 32'd0, 1);
        step(); i_type(T_I, 3'b101, 5'd22, 5'd23, 12'h404, 32'd0);
        push(5'd22, 32'hF8000000, 1);
        step(); i_type(T_I, 3'b101, 5'd24, 5'd23, 12'h004, 32'd0);
        push(5'd24, 32'h08000000, 1);
        step(); r_type(7'h00, 3'b111, 5'd25, 5'd23, 5'd11);
        push(5'd25, 32'h80000000, 1);
        step(); r_type(7'h00, 3'b001, 5'd26, 5'd12, 5'd12);
        push(5'd26, 32'd2, 1);
        idle(4);

        // Signed vs unsigned compare: -1 < 1 only when signed.
        step(); b_type(3'b100, 5'd11, 5'd12, 32'h10, 32'h80);
        step(); nop();
        @(negedge clk);
        chk("blt_taken", 32'(PCSrc), 32'd1);
        step(); b_type(3'b110, 5'd11, 5'd12, 32'h10, 32'h90);
        step(); nop();
        @(negedge clk);
        chk("bltu_not_taken", 32'(PCSrc), 32'd0);
        idle(4);

        // Decode bypass: x17 is in WB while add x18 is captured.
        step(); i_type(T_I, 3'b000, 5'd17, 5'd0, 12'd3, 32'd0);
        push(5'd17, 32'd3, 0);
        idle(2);
        step(); r_type(7'h00, 3'b000, 5'd18, 5'd17, 5'd17);
        push(5'd18, 32'd6, 3);
        idle(4);

        // Store then load back.
        step(); s_type(5'd0, 5'd2, 12'd8);
        step(); i_type(T_LD, 3'b010, 5'd6, 5'd0, 12'd8, 32'd0);
        push(5'd6, 32'hDEADBEEF, 0);
        step(); nop();
        @(negedge clk);
        chk("st_we", 32'(dmem_we), 32'd1);
        chk("st_addr", dmem_addr, 32'd8);
        chk("st_wdata", dmem_wdata, 32'hDEADBEEF);
        idle(4);

        // Reset with x19 in WB, x20 in MEM and a taken beq in EX.
        step(); i_type(T_I, 3'b000, 5'd19, 5'd0, 12'd1, 32'd0);
        push(5'd19, 32'd1, 0);
        step(); i_type(T_I, 3'b000, 5'd20, 5'd0, 12'd2, 32'd0);
        step(); b_type(3'b000, 5'd0, 5'd0, 32'd4, 32'h60);
        step(); nop();
        @(negedge clk);
        #2;
        chk("rm_pcsrc_pre", 32'(PCSrc), 32'd1);
        chk("rm_regwrite_pre", 32'(RegWrite_WB), 32'd1);
        reset = 1'b0;
        #1;
        chk("rm_pcsrc", 32'(PCSrc), 32'd0);
        chk("rm_regwrite", 32'(RegWrite_WB), 32'd0);
        chk("rm_rd", 32'(RD_WB), 32'd0);
        chk("rm_we", 32'(dmem_we), 32'd0);
        step();
        step();
        reset = 1'b1;
        idle(6);

        idle(4);
        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
